wb_dbg_master: RTL and testbench
================================

WB_DBG_MASTER -- requirements
Module: wb_dbg_master

Interface
REQ-001 SHALL have parameter AW, default 16, meaning Wishbone word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning Wishbone data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT_W, default 8, meaning bus-timeout counter width.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset; there is one clock and reset is synchronous and active-high.
REQ-006 SHALL have port rx_data, input, 8, meaning command byte stream in (from UART receiver).
REQ-007 SHALL have port rx_valid / rx_ready, input / output, 1 each, meaning the command-stream handshake; a byte transfers when both are high at a clk edge.
REQ-008 SHALL have port tx_data, output, 8, meaning response byte stream out.
REQ-009 SHALL have port tx_valid / tx_ready, output / input, 1 each, meaning the response-stream handshake.
REQ-010 SHALL have Wishbone initiator ports: wb_addr (output, AW), wb_wdata (output, 32), wb_wmsk (output, 4), wb_we (output, 1), wb_cyc (output, 1), wb_rdata (input, 32), wb_ack (input, 1).

Function
REQ-011 SHALL define a request frame as: cmd byte, then addr[15:8], then addr[7:0], then, for writes only, 4 data bytes MSB first; cmd[7:4] is the opcode (0x1 write, 0x2 read) and cmd[3:0] is the write byte mask.
REQ-012 SHALL implement FSM states IDLE -> ADDR (2 bytes) -> WDATA (4 bytes, writes only) -> BUS -> RESP -> IDLE.
REQ-013 SHALL drop, in IDLE, any cmd byte with an opcode other than 0x1 or 0x2, stay in IDLE and emit no response.
REQ-014 SHALL drive rx_ready high in IDLE, ADDR and WDATA and low in BUS and RESP.
REQ-015 SHALL raise wb_cyc on the clk edge that accepts the last request byte, so wb_cyc is high in the following cycle.
REQ-016 SHALL hold wb_addr, wb_wdata, wb_wmsk and wb_we stable while wb_cyc is high; wb_wmsk = cmd[3:0] for writes and 4'b0000 for reads; wb_we = 1 only for writes.
REQ-017 SHALL, when wb_ack is sampled high with wb_cyc high, drop wb_cyc on that edge, capture wb_rdata for reads, and enter RESP.
REQ-018 SHALL ignore wb_ack whenever wb_cyc is low.
REQ-019 SHALL produce, in RESP: for a write, the single status byte 0xA5; for a read, 0xA5 followed by rdata[31:24], [23:16], [15:8], [7:0].
REQ-020 SHALL hold tx_valid and tx_data stable until tx_ready is sampled high, advancing one byte per accepted transfer, and return to IDLE after the last byte is accepted.
REQ-021 SHALL accept no new request bytes until the current response completes; there is no pipelining and at most one Wishbone cycle is outstanding.
REQ-022 SHALL accept frame bytes that arrive with arbitrary idle gaps; there is no inter-byte timeout.

Reset
REQ-023 SHALL, while rst is high at a clk edge, force state IDLE, wb_cyc=0, wb_we=0, wb_wmsk=0, wb_addr=0, wb_wdata=0, tx_valid=0, tx_data=0, rx_ready=0, timeout counter=0.
REQ-024 SHALL discard any partial frame or in-flight bus cycle on reset; wb_cyc is low in the cycle after the reset edge.
REQ-025 SHALL raise rx_ready in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, when macro WB_DBG_TIMEOUT_EN is defined, count cycles in BUS; if 2^TIMEOUT_W-1 cycles elapse with no ack, drop wb_cyc and respond with the single byte 0xEE (no data bytes, for reads as well as writes).
REQ-027 SHALL, when WB_DBG_TIMEOUT_EN is undefined, omit the counter entirely and wait in BUS indefinitely for wb_ack.
REQ-028 SHALL resolve an ack arriving in the same cycle the timeout expires as an ack (response 0xA5).

Structure
REQ-029 SHALL place the opcodes (0x1, 0x2), the status bytes (0xA5, 0xEE) and the FSM state encoding in shared package wb_dbg_pkg.
REQ-030 SHALL be a single module with no sub-modules; byte shift registers and counters are inline.

Verification
REQ-031 SHALL cover: write frame 0x1F,0x00,0x10,0xDE,0xAD,0xBE,0xEF with an ack 2 cycles later -> wb_addr=0x0010, wb_wdata=0xDEADBEEF, wb_wmsk=0xF, wb_we=1, then tx byte 0xA5.
REQ-032 SHALL cover: read frame 0x20,0x12,0x34 with the slave returning 0xCAFEF00D -> wb_we=0, wb_wmsk=0, then tx bytes 0xA5,0xCA,0xFE,0xF0,0x0D.
REQ-033 SHALL cover: cmd 0x70 followed by a valid read frame -> 0x70 dropped, read completes normally, exactly 5 tx bytes.
REQ-034 SHALL cover: with WB_DBG_TIMEOUT_EN and TIMEOUT_W=4, a read with no ack -> wb_cyc low after 15 cycles, single tx byte 0xEE.
REQ-035 SHALL cover: tx_ready held low for 10 cycles during a read response -> tx_data stable, no byte lost or duplicated, rx_ready low throughout.
REQ-036 SHALL cover: rst asserted while wb_cyc=1 -> wb_cyc=0 the next cycle, no response emitted, and the next frame is processed correctly.

Source files
------------

// File: rtl/wb_dbg_pkg.sv
// Shared constants for the byte-stream Wishbone debug master: opcodes,
// response status bytes and the controller state encoding.
package wb_dbg_pkg;

   localparam logic [3:0] OP_WRITE   = 4'h1;
   localparam logic [3:0] OP_READ    = 4'h2;
   localparam logic [7:0] ST_OK      = 8'hA5;
   localparam logic [7:0] ST_TIMEOUT = 8'hEE;
   localparam int         RD_BYTES   = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_BUS,
      S_RESP
   } state_t;

   function automatic logic isValidOp(input logic [3:0] op);
      return (op == OP_WRITE) || (op == OP_READ);
   endfunction

endpackage

// File: rtl/wb_dbg_master.sv
// Byte-stream command decoder driving a single-outstanding Wishbone initiator.
// Optional bus timeout is enabled by defining WB_DBG_TIMEOUT_EN.
module wb_dbg_master
   import wb_dbg_pkg::*;
#(
   parameter int AW        = 16,
   parameter int DW        = 32,
   parameter int TIMEOUT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [AW-1:0] wb_addr,
   output logic [DW-1:0] wb_wdata,
   output logic [3:0]    wb_wmsk,
   output logic          wb_we,
   output logic          wb_cyc,
   input  logic [DW-1:0] wb_rdata,
   input  logic          wb_ack
);

   state_t        state_q;
   logic          rxReady_q;
   logic          isWrite_q;
   logic [3:0]    mask_q;
   logic [1:0]    byteCnt_q;
   logic [15:0]   addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic [2:0]    respLeft_q;
   logic          wbCyc_q;
   logic          wbWe_q;
   logic [3:0]    wbWmsk_q;
   logic          txValid_q;
   logic [7:0]    txData_q;

`ifdef WB_DBG_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   logic [TIMEOUT_W-1:0] tmo_q;
`else
   logic unusedTimeoutW;
   assign unusedTimeoutW = (TIMEOUT_W > 0);
`endif

   // rx_ready is registered from the next state, so it drops on the edge
   // that takes the last request byte and rises as the response completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rxReady_q  <= 1'b0;
         isWrite_q  <= 1'b0;
         mask_q     <= 4'h0;
         byteCnt_q  <= 2'd0;
         addr_q     <= 16'h0000;
         wdata_q    <= '0;
         rdata_q    <= '0;
         respLeft_q <= 3'd0;
         wbCyc_q    <= 1'b0;
         wbWe_q     <= 1'b0;
         wbWmsk_q   <= 4'h0;
         txValid_q  <= 1'b0;
         txData_q   <= 8'h00;
`ifdef WB_DBG_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               rxReady_q <= 1'b1;
               if (rx_valid && rxReady_q && isValidOp(rx_data[7:4])) begin
                  isWrite_q <= (rx_data[7:4] == OP_WRITE);
                  mask_q    <= rx_data[3:0];
                  byteCnt_q <= 2'd0;
                  state_q   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_valid && rxReady_q) begin
                  addr_q    <= {addr_q[7:0], rx_data};
                  byteCnt_q <= byteCnt_q + 2'd1;
                  if (byteCnt_q == 2'd1) begin
                     byteCnt_q <= 2'd0;
                     if (isWrite_q) begin
                        state_q <= S_WDATA;
                     end else begin
                        state_q   <= S_BUS;
                        wbCyc_q   <= 1'b1;
                        wbWe_q    <= 1'b0;
                        wbWmsk_q  <= 4'h0;
                        rxReady_q <= 1'b0;
                     end
                  end
               end
            end
            S_WDATA: begin
               if (rx_valid && rxReady_q) begin
                  wdata_q   <= {wdata_q[DW-9:0], rx_data};
                  byteCnt_q <= byteCnt_q + 2'd1;
                  if (byteCnt_q == 2'd3) begin
                     state_q   <= S_BUS;
                     wbCyc_q   <= 1'b1;
                     wbWe_q    <= 1'b1;
                     wbWmsk_q  <= mask_q;
                     rxReady_q <= 1'b0;
                  end
               end
            end
            S_BUS: begin
               // An ack wins over a timeout expiring on the same edge.
               if (wbCyc_q && wb_ack) begin
                  wbCyc_q    <= 1'b0;
                  rdata_q    <= wb_rdata;
                  txValid_q  <= 1'b1;
                  txData_q   <= ST_OK;
                  respLeft_q <= isWrite_q ? 3'd0 : 3'(RD_BYTES);
                  state_q    <= S_RESP;
`ifdef WB_DBG_TIMEOUT_EN
                  tmo_q      <= '0;
               end else if (tmo_q == TMO_LAST) begin
                  wbCyc_q    <= 1'b0;
                  txValid_q  <= 1'b1;
                  txData_q   <= ST_TIMEOUT;
                  respLeft_q <= 3'd0;
                  state_q    <= S_RESP;
                  tmo_q      <= '0;
               end else begin
                  tmo_q      <= tmo_q + 1'b1;
`endif
               end
            end
            S_RESP: begin
               if (tx_ready) begin
                  if (respLeft_q == 3'd0) begin
                     txValid_q <= 1'b0;
                     rxReady_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     txData_q   <= rdata_q[DW-1 -: 8];
                     rdata_q    <= {rdata_q[DW-9:0], 8'h00};
                     respLeft_q <= respLeft_q - 3'd1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_ready = rxReady_q;
   assign tx_valid = txValid_q;
   assign tx_data  = txData_q;
   assign wb_addr  = AW'(addr_q);
   assign wb_wdata = wdata_q;
   assign wb_wmsk  = wbWmsk_q;
   assign wb_we    = wbWe_q;
   assign wb_cyc   = wbCyc_q;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Randomized self-checking bench for wb_dbg_master; expected responses come
// from a frame-level model (status byte plus read word, MSB first).
module tb_wb_dbg_master;

   localparam int AW = 16;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic [AW-1:0] wb_addr;
   logic [31:0]   wb_wdata;
   logic [3:0]    wb_wmsk;
   logic          wb_we;
   logic          wb_cyc;
   logic [31:0]   wb_rdata = 32'h0;
   logic          wb_ack = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        sendOk;
      logic        cycAfterLast;
      int          cycHigh;
      logic        busStable;
      logic        dropOk;
      logic [15:0] a;
      logic [31:0] wd;
      logic [3:0]  m;
      logic        we;
      logic [47:0] resp;
      logic        txStable;
      logic        rxLow;
   } obs_t;

   wb_dbg_master #(.AW(AW), .DW(32), .TIMEOUT_W(TW)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we),
      .wb_cyc(wb_cyc), .wb_rdata(wb_rdata), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   // Expected response as {byte count, up to five bytes in order}.
   function automatic logic [47:0] expectResp(input logic isWrite, input logic timedOut, input logic [31:0] rd);
      if (timedOut) return {8'd1, 8'hEE, 32'd0};
      if (isWrite) return {8'd1, 8'hA5, 32'd0};
      return {8'd5, 8'hA5, rd};
   endfunction

   function automatic logic [47:0] packResp(input logic [7:0] q[$]);
      logic [47:0] p;
      p = '0;
      p[47:40] = 8'(q.size());
      for (int i = 0; i < 5 && i < q.size(); i++) p[39-8*i -: 8] = q[i];
      return p;
   endfunction

   task automatic sendByte(input logic [7:0] b, input int gap, output logic ok);
      logic rdy;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data = b;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         rdy = rx_ready;
         @(negedge clk);
         ok = rdy;
      end
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic sendFrame(input logic [7:0] fr[$], input int maxGap, output logic ok);
      logic one;
      ok = 1'b1;
      foreach (fr[i]) begin
         sendByte(fr[i], int'($urandom_range(0, maxGap)), one);
         ok &= one;
      end
   endtask

   task automatic serviceBus(input int delay, input logic [31:0] rd, output int high, output logic stable,
                             output logic [15:0] a, output logic [31:0] wd, output logic [3:0] m,
                             output logic we, output logic dropped);
      high = 0;
      stable = 1'b1;
      a = wb_addr; wd = wb_wdata; m = wb_wmsk; we = wb_we;
      while (wb_cyc === 1'b1 && high < 200) begin
         high++;
         if (wb_addr !== a || wb_wdata !== wd || wb_wmsk !== m || wb_we !== we) stable = 1'b0;
         if (high == delay + 1) begin
            wb_ack = 1'b1;
            wb_rdata = rd;
         end
         @(negedge clk);
         wb_ack = 1'b0;
         wb_rdata = $urandom;
      end
      dropped = (wb_cyc === 1'b0);
   endtask

   task automatic collectResp(input int stallAt, input int stallLen, input bit randReady,
                              output logic [7:0] q[$], output logic stableOk, output logic rxLowOk);
      int idle;
      int stalled;
      logic held;
      logic [7:0] heldData;
      idle = 0; stalled = 0; held = 1'b0; heldData = 8'h00;
      q = {};
      stableOk = 1'b1;
      rxLowOk = 1'b1;
      for (int n = 0; n < 400 && idle < 12; n++) begin
         if (held && (tx_valid !== 1'b1 || tx_data !== heldData)) stableOk = 1'b0;
         if (tx_valid === 1'b1 && rx_ready !== 1'b0) rxLowOk = 1'b0;
         if (tx_valid === 1'b1) begin
            idle = 0;
            if (q.size() == stallAt && stalled < stallLen) begin
               tx_ready = 1'b0;
               stalled++;
            end else begin
               tx_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (tx_ready) q.push_back(tx_data);
         end else begin
            idle++;
            tx_ready = 1'b0;
         end
         held = tx_valid && !tx_ready;
         heldData = tx_data;
         @(negedge clk);
      end
      tx_ready = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] wd,
                                input int maxGap, input int ackDelay, input logic [31:0] rd,
                                input int stallAt, input int stallLen, input bit randReady, output obs_t o);
      logic [7:0] fr[$];
      logic [7:0] rq[$];
      int hi; logic st, dr, we; logic [15:0] a; logic [31:0] w; logic [3:0] m;
      logic ok, ts, rl;
      fr.push_back(cmd);
      fr.push_back(addr[15:8]);
      fr.push_back(addr[7:0]);
      if (cmd[7:4] == 4'h1) for (int i = 3; i >= 0; i--) fr.push_back(wd[8*i +: 8]);
      sendFrame(fr, maxGap, ok);
      o.sendOk = ok;
      o.cycAfterLast = wb_cyc;
      hi = 0; st = 1'b0; dr = 1'b0; a = '0; w = '0; m = '0; we = 1'b0;
      if (wb_cyc === 1'b1) serviceBus(ackDelay, rd, hi, st, a, w, m, we, dr);
      o.cycHigh = hi; o.busStable = st; o.dropOk = dr;
      o.a = a; o.wd = w; o.m = m; o.we = we;
      collectResp(stallAt, stallLen, randReady, rq, ts, rl);
      o.resp = packResp(rq);
      o.txStable = ts;
      o.rxLow = rl;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({wb_cyc, wb_we, wb_wmsk, wb_addr, wb_wdata} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_wb got=%b/%b/%h/%h/%h want all zero", wb_cyc, wb_we, wb_wmsk, wb_addr, wb_wdata);
      end
      checks++;
      if ({tx_valid, tx_data, rx_ready} !== 10'd0) begin
         failures++;
         $display("[TB] FAIL reset_stream got tx_valid=%b tx_data=%h rx_ready=%b want 0/00/0", tx_valid, tx_data, rx_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_rx_ready_rise got=%b want=1", rx_ready);
      end
   endtask

   task automatic test_write();
      obs_t o;
      applyStimulus(8'h1F, 16'h0010, 32'hDEADBEEF, 0, 2, 32'h0, 0, 0, 1'b0, o);
      checks++;
      if ({o.sendOk, o.cycAfterLast} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL write_cyc_rise got send=%b cyc=%b want 1/1", o.sendOk, o.cycAfterLast);
      end
      checks++;
      if ({o.a, o.wd, o.m, o.we} !== {16'h0010, 32'hDEADBEEF, 4'hF, 1'b1}) begin
         failures++;
         $display("[TB] FAIL write_fields got addr=%h data=%h msk=%h we=%b want 0010/DEADBEEF/F/1", o.a, o.wd, o.m, o.we);
      end
      checks++;
      if ({o.busStable, o.dropOk} !== 2'b11 || o.cycHigh != 3) begin
         failures++;
         $display("[TB] FAIL write_bus got stable=%b drop=%b cycHigh=%0d want 1/1/3", o.busStable, o.dropOk, o.cycHigh);
      end
      checks++;
      if (o.resp !== expectResp(1'b1, 1'b0, 32'h0)) begin
         failures++;
         $display("[TB] FAIL write_resp got=%h want=%h", o.resp, expectResp(1'b1, 1'b0, 32'h0));
      end
   endtask

   task automatic test_read();
      obs_t o;
      applyStimulus(8'h20, 16'h1234, 32'h0, 1, 1, 32'hCAFEF00D, 0, 0, 1'b0, o);
      checks++;
      if ({o.sendOk, o.cycAfterLast, o.a, o.m, o.we} !== {2'b11, 16'h1234, 4'h0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL read_fields got cyc=%b addr=%h msk=%h we=%b want 1/1234/0/0", o.cycAfterLast, o.a, o.m, o.we);
      end
      checks++;
      if (o.resp !== expectResp(1'b0, 1'b0, 32'hCAFEF00D)) begin
         failures++;
         $display("[TB] FAIL read_resp got=%h want=%h", o.resp, expectResp(1'b0, 1'b0, 32'hCAFEF00D));
      end
   endtask

   task automatic test_bad_opcode();
      obs_t o;
      logic [7:0] fr[$];
      logic ok, quiet;
      logic [31:0] rd;
      fr.push_back(8'h70);
      sendFrame(fr, 0, ok);
      quiet = ok;
      repeat (4) begin
         if (wb_cyc !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) quiet = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (quiet !== 1'b1) begin
         failures++;
         $display("[TB] FAIL badop_dropped got quiet=%b want=1", quiet);
      end
      rd = $urandom;
      applyStimulus(8'h20, 16'h0042, 32'h0, 0, 0, rd, 0, 0, 1'b0, o);
      checks++;
      if (o.resp !== expectResp(1'b0, 1'b0, rd) || o.a !== 16'h0042) begin
         failures++;
         $display("[TB] FAIL badop_next_read got resp=%h addr=%h want %h/0042", o.resp, o.a, expectResp(1'b0, 1'b0, rd));
      end
   endtask

   task automatic test_backpressure();
      obs_t o;
      logic [31:0] rd;
      rd = $urandom;
      applyStimulus(8'h2A, 16'h8001, 32'h0, 0, 0, rd, 2, 10, 1'b0, o);
      checks++;
      if ({o.txStable, o.rxLow} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL stall_stable got txStable=%b rxLow=%b want 1/1", o.txStable, o.rxLow);
      end
      checks++;
      if (o.resp !== expectResp(1'b0, 1'b0, rd)) begin
         failures++;
         $display("[TB] FAIL stall_resp got=%h want=%h", o.resp, expectResp(1'b0, 1'b0, rd));
      end
   endtask

   task automatic test_reset_midcycle();
      obs_t o;
      logic [7:0] fr[$];
      logic ok, quiet;
      fr.push_back(8'h20); fr.push_back(8'hAB); fr.push_back(8'hCD);
      sendFrame(fr, 0, ok);
      repeat (2) @(negedge clk);
      checks++;
      if ({ok, wb_cyc} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL rstmid_cyc_before got send=%b cyc=%b want 1/1", ok, wb_cyc);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({wb_cyc, tx_valid, rx_ready} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL rstmid_cyc_drop got cyc=%b txv=%b rdy=%b want 0/0/0", wb_cyc, tx_valid, rx_ready);
      end
      rst = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wb_ack = (i == 2);
         wb_rdata = $urandom;
         @(negedge clk);
         if (wb_cyc !== 1'b0 || tx_valid !== 1'b0) quiet = 1'b0;
      end
      wb_ack = 1'b0;
      checks++;
      if (quiet !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rstmid_no_resp got quiet=%b want=1", quiet);
      end
      applyStimulus(8'h13, 16'hBEEF, 32'h01234567, 2, 1, 32'h0, 0, 0, 1'b0, o);
      checks++;
      if ({o.a, o.wd, o.m, o.we} !== {16'hBEEF, 32'h01234567, 4'h3, 1'b1} || o.resp !== expectResp(1'b1, 1'b0, 32'h0)) begin
         failures++;
         $display("[TB] FAIL rstmid_next_write got addr=%h data=%h msk=%h we=%b resp=%h", o.a, o.wd, o.m, o.we, o.resp);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      logic [31:0] rd;
      rd = $urandom;
`ifdef WB_DBG_TIMEOUT_EN
      applyStimulus(8'h20, 16'h0BAD, 32'h0, 0, -1, rd, 0, 0, 1'b0, o);
      checks++;
      if (o.cycHigh != 15 || o.dropOk !== 1'b1 || o.resp !== expectResp(1'b0, 1'b1, rd)) begin
         failures++;
         $display("[TB] FAIL timeout_read got cycHigh=%0d resp=%h want 15/%h", o.cycHigh, o.resp, expectResp(1'b0, 1'b1, rd));
      end
      applyStimulus(8'h15, 16'h0BAD, 32'h55AA55AA, 0, -1, rd, 0, 0, 1'b0, o);
      checks++;
      if (o.cycHigh != 15 || o.resp !== expectResp(1'b1, 1'b1, rd)) begin
         failures++;
         $display("[TB] FAIL timeout_write got cycHigh=%0d resp=%h want 15/%h", o.cycHigh, o.resp, expectResp(1'b1, 1'b1, rd));
      end
      applyStimulus(8'h20, 16'h0ACE, 32'h0, 0, 14, rd, 0, 0, 1'b0, o);
      checks++;
      if (o.cycHigh != 15 || o.resp !== expectResp(1'b0, 1'b0, rd)) begin
         failures++;
         $display("[TB] FAIL timeout_ack_tie got cycHigh=%0d resp=%h want 15/%h", o.cycHigh, o.resp, expectResp(1'b0, 1'b0, rd));
      end
`else
      applyStimulus(8'h20, 16'h0ACE, 32'h0, 0, 40, rd, 0, 0, 1'b0, o);
      checks++;
      if (o.cycHigh != 41 || o.resp !== expectResp(1'b0, 1'b0, rd)) begin
         failures++;
         $display("[TB] FAIL long_wait got cycHigh=%0d resp=%h want 41/%h", o.cycHigh, o.resp, expectResp(1'b0, 1'b0, rd));
      end
`endif
   endtask

   task automatic test_random();
      obs_t o;
      logic [7:0] cmd;
      logic [7:0] fr[$];
      logic [15:0] addr;
      logic [31:0] wd, rd;
      logic isWr, ok;
      int delay, op;
      for (int t = 0; t < 20; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            op = int'($urandom_range(0, 13));
            if (op >= 1) op += 2;
            fr = {};
            fr.push_back({4'(op), 4'($urandom_range(0, 15))});
            sendFrame(fr, 2, ok);
            repeat (2) @(negedge clk);
            checks++;
            if ({ok, wb_cyc, rx_ready, tx_valid} !== 4'b1010) begin
               failures++;
               $display("[TB] FAIL rand_badop op=%h got send=%b cyc=%b rdy=%b txv=%b", op, ok, wb_cyc, rx_ready, tx_valid);
            end
         end
         isWr = 1'($urandom_range(0, 1));
         cmd = {isWr ? 4'h1 : 4'h2, 4'($urandom_range(0, 15))};
         addr = 16'($urandom);
         wd = $urandom;
         rd = $urandom;
         delay = int'($urandom_range(0, 8));
         applyStimulus(cmd, addr, wd, int'($urandom_range(0, 3)), delay, rd,
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b1, o);
         checks++;
         if ({o.sendOk, o.cycAfterLast, o.a, o.m, o.we} !== {2'b11, addr, isWr ? cmd[3:0] : 4'h0, isWr}) begin
            failures++;
            $display("[TB] FAIL rand_fields t=%0d cmd=%h got addr=%h msk=%h we=%b want addr=%h", t, cmd, o.a, o.m, o.we, addr);
         end
         if (isWr) begin
            checks++;
            if (o.wd !== wd) begin
               failures++;
               $display("[TB] FAIL rand_wdata t=%0d got=%h want=%h", t, o.wd, wd);
            end
         end
         checks++;
         if ({o.busStable, o.dropOk} !== 2'b11 || o.cycHigh != delay + 1) begin
            failures++;
            $display("[TB] FAIL rand_bus t=%0d got stable=%b drop=%b cycHigh=%0d want 1/1/%0d", t, o.busStable, o.dropOk, o.cycHigh, delay + 1);
         end
         checks++;
         if (o.resp !== expectResp(isWr, 1'b0, rd) || {o.txStable, o.rxLow} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rand_resp t=%0d got=%h want=%h stable=%b rxLow=%b", t, o.resp, expectResp(isWr, 1'b0, rd), o.txStable, o.rxLow);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_opcode();
      test_backpressure();
      test_reset_midcycle();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

endmodule
